fp_mul_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined `fp_mul` single-precision multiplier among `NREQ` requesters. It accepts packed IEEE-754 operand pairs, unpacks them onto the multiplier's sign/exponent/mantissa ports, and tracks each in-flight operation with a requester-ID tag pipeline. Each result returns to its owner on a shared response bus. It sits between the SFU issue logic and the `fp_mul` instance, and drives that instance's active-low reset.

---
 rtl/fp_mul_arb.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arb
// Purpose  : Round-robin sharing of one pipelined fp_mul among NREQ requesters,
//            with a requester-ID tag pipeline routing results back to owners.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*32-1:0]        req_a,
  input  logic [NREQ*32-1:0]        req_b,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [31:0]               rsp_r,
  output logic                      m_rstn,
  output logic                      m_src_valid,
  output logic [22:0]               m_a_man,
  output logic [7:0]                m_a_exp,
  output logic                      m_a_sign,
  output logic [22:0]               m_b_man,
  output logic [7:0]                m_b_exp,
  output logic                      m_b_sign,
  input  logic [22:0]               m_r_man,
  input  logic [7:0]                m_r_exp,
  input  logic                      m_r_sign,
  input  logic                      m_dst_valid,
  output logic [$clog2(LAT+1)-1:0]  inflight,
  output logic                      err_unexp,
  output logic                      err_miss
);

  localparam int c_cnt_w = $clog2(LAT+1);

  logic [IDW-1:0]     r_ptr;
  logic [NREQ-1:0]    w_rot;
  logic [IDW-1:0]     w_off;
  logic [IDW:0]       w_sum;
  logic               w_gnt_any;
  logic [IDW-1:0]     w_gnt_id;
  logic [NREQ-1:0]    w_gnt;
  logic               w_accept;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [31:0]        w_a;
  logic [31:0]        w_b;

  logic               r_src_valid;
  logic [IDW-1:0]     r_src_id;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [LAT-1:0]     r_tag_v;
  logic [IDW-1:0]     r_tag_id [LAT];
  logic [NREQ-1:0]    r_rsp_valid;
  logic [31:0]        r_rsp_r;
  logic               r_err_unexp;
  logic               r_err_miss;

  logic               w_hit;
  logic [NREQ-1:0]    w_rsp_oh;
  logic [c_cnt_w-1:0] w_cnt;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    w_rot     = NREQ'({req_valid, req_valid} >> r_ptr);
    w_gnt_any = 1'b0;
    w_off     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_gnt_any = 1'b1;
        w_off     = IDW'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDW+1)'(NREQ)) begin
      w_sum = w_sum - (IDW+1)'(NREQ);
    end
    w_gnt_id = w_sum[IDW-1:0];
  end

  always_comb begin
    w_gnt = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_gnt[i] = w_gnt_any;
        w_a      = req_a[i*32 +: 32];
        w_b      = req_b[i*32 +: 32];
      end
    end
  end

  assign req_ready = (en && !rst) ? w_gnt : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

  assign w_hit = r_tag_v[LAT-1] & m_dst_valid;

  always_comb begin
    w_rsp_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_oh[i] = (r_tag_id[LAT-1] == IDW'(i));
    end
  end

  // Operations still inside the multiplier: the output stage is excluded
  // because its result is on the multiplier outputs this cycle.
  always_comb begin
    w_cnt = c_cnt_w'(r_src_valid);
    for (int k = 0; k < LAT-1; k++) begin
      w_cnt = w_cnt + c_cnt_w'(r_tag_v[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_src_valid <= 1'b0;
      r_src_id    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag_v     <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_tag_id[k] <= '0;
      end
      r_rsp_valid <= '0;
      r_rsp_r     <= '0;
      r_err_unexp <= 1'b0;
      r_err_miss  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr    <= w_ptr_nxt;
        r_src_id <= w_gnt_id;
        r_a      <= w_a;
        r_b      <= w_b;
      end
      r_src_valid <= w_accept;
      // Tag follows the issue strobe so the last stage lines up with dst_valid.
      r_tag_v[0]  <= r_src_valid;
      r_tag_id[0] <= r_src_id;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
      r_rsp_valid <= w_hit ? w_rsp_oh : '0;
      if (w_hit) begin
        r_rsp_r <= {m_r_sign, m_r_exp, m_r_man};
      end
      if (m_dst_valid && !r_tag_v[LAT-1]) begin
        r_err_unexp <= 1'b1;
      end
      if (r_tag_v[LAT-1] && !m_dst_valid) begin
        r_err_miss <= 1'b1;
      end
    end
  end

  assign m_rstn      = ~rst;
  assign m_src_valid = r_src_valid;
  assign {m_a_sign, m_a_exp, m_a_man} = r_a;
  assign {m_b_sign, m_b_exp, m_b_man} = r_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_r       = r_rsp_r;
  assign inflight    = w_cnt;
  assign err_unexp   = r_err_unexp;
  assign err_miss    = r_err_miss;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_arb
// Purpose  : Directed scoreboard bench for fp_mul_arb with a table-driven
//            fixed-latency multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int NV   = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_r;
  logic                 m_rstn;
  logic                 m_src_valid;
  logic [22:0]          m_a_man;
  logic [7:0]           m_a_exp;
  logic                 m_a_sign;
  logic [22:0]          m_b_man;
  logic [7:0]           m_b_exp;
  logic                 m_b_sign;
  logic [22:0]          m_r_man;
  logic [7:0]           m_r_exp;
  logic                 m_r_sign;
  logic                 m_dst_valid;
  logic [1:0]           inflight;
  logic                 err_unexp;
  logic                 err_miss;

  logic                 kill_src;
  logic                 inject;
  logic                 track;
  int                   peak = 0;
  int                   tests = 0;
  int                   fails = 0;
  int                   cyc = 0;

  // Hand-computed IEEE-754 products: a * b = r
  logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h3F800000, 32'h40000000, 32'h40800000,
                           32'h41000000, 32'h41800000, 32'hC0000000, 32'h3F000000};
  logic [31:0] vb [NV] = '{32'h3FC00000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                           32'h3F000000, 32'h40000000, 32'h40000000, 32'h40000000,
                           32'h40000000, 32'h40000000, 32'h40400000, 32'h3F000000};
  logic [31:0] vr [NV] = '{32'h40100000, 32'h3F000000, 32'h3F800000, 32'h3FC00000,
                           32'h40000000, 32'h40000000, 32'h40800000, 32'h41000000,
                           32'h41800000, 32'h42000000, 32'hC0C00000, 32'h3E800000};

  typedef struct {
    int          id;
    logic [31:0] r;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  fp_mul_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .m_rstn(m_rstn), .m_src_valid(m_src_valid),
    .m_a_man(m_a_man), .m_a_exp(m_a_exp), .m_a_sign(m_a_sign),
    .m_b_man(m_b_man), .m_b_exp(m_b_exp), .m_b_sign(m_b_sign),
    .m_r_man(m_r_man), .m_r_exp(m_r_exp), .m_r_sign(m_r_sign),
    .m_dst_valid(m_dst_valid), .inflight(inflight),
    .err_unexp(err_unexp), .err_miss(err_miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NV; i++) begin
      if (va[i] == a && vb[i] == b) return vr[i];
    end
    return 32'hFFFFFFFF;
  endfunction

  // Fixed-latency multiplier stand-in
  logic [LAT-1:0] mv;
  logic [31:0]    mr [LAT];
  always @(posedge clk) begin
    if (!m_rstn) begin
      mv <= '0;
      for (int k = 0; k < LAT; k++) mr[k] <= '0;
    end else begin
      mv[0] <= m_src_valid & ~kill_src;
      mr[0] <= mul_lut({m_a_sign, m_a_exp, m_a_man}, {m_b_sign, m_b_exp, m_b_man});
      for (int k = 1; k < LAT; k++) begin
        mv[k] <= mv[k-1];
        mr[k] <= mr[k-1];
      end
    end
  end
  assign m_dst_valid = mv[LAT-1] | inject;
  assign {m_r_sign, m_r_exp, m_r_man} = mr[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (track) begin
      if (int'(inflight) > peak) peak = int'(inflight);
    end else begin
      peak = 0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b rsp_r=0x%0h, expected no response (cycle %0d)",
                 rsp_valid, rsp_r, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
        chk("rsp_r", rsp_r, e.r);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_op(input int id, input int vi);
    req_a[id*32 +: 32] = va[vi];
    req_b[id*32 +: 32] = vb[vi];
  endtask

  task automatic issue(input int id, input int vi, input bit push);
    set_op(id, vi);
    req_valid = 4'(1 << id);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(1 << id));
    if (push) sb.push_back('{id, vr[vi], cyc + LAT + 2});
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    kill_src = 1'b0; inject = 1'b0; track = 1'b0;
    repeat (2) @(posedge clk);
    #1; req_valid = 4'hF;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_src_valid", 32'(m_src_valid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_errs", 32'({err_unexp, err_miss}), 0);
    chk("rst_m_rstn", 32'(m_rstn), 0);
    chk("rst_opnd_a", {m_a_sign, m_a_exp, m_a_man}, 0);
    chk("rst_opnd_b", {m_b_sign, m_b_exp, m_b_man}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("m_rstn_run", 32'(m_rstn), 1);
    @(posedge clk); #1;

    // single op: requester 2, 1.5 * 1.5
    issue(2, 0, 1);
    idle(LAT + 3);

    // en gating with two ops in flight
    issue(1, 10, 1);
    issue(3, 11, 1);
    en = 1'b0; set_op(0, 0); set_op(2, 0); req_valid = 4'b0101;
    @(negedge clk);
    chk("en_inflight", 32'(inflight), 2);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      chk("en_gate", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    req_valid = '0; en = 1'b1;
    idle(LAT + 3);
    @(negedge clk);
    chk("en_drain", 32'(inflight), 0);
    @(posedge clk); #1;

    // fairness: all requesters held valid
    for (int i = 0; i < NREQ; i++) set_op(i, 1 + i);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      sb.push_back('{k % 4, vr[1 + k % 4], cyc + LAT + 2});
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle(LAT + 3);

    // back-to-back stream from requester 0
    track = 1'b1;
    for (int j = 0; j < 5; j++) issue(0, 5 + j, 1);
    idle(LAT + 3);
    chk("inflight_peak", peak, LAT);
    track = 1'b0;
    @(negedge clk);
    chk("b2b_drain", 32'(inflight), 0);
    @(posedge clk); #1;

    // reset with LAT ops in flight
    for (int j = 0; j < LAT; j++) issue(2, 0, 0);
    @(negedge clk);
    chk("pre_rst_inflight", 32'(inflight), LAT);
    rst = 1'b1; set_op(2, 0); set_op(3, 1); req_valid = 4'b1100;
    #1;
    chk("rst_force_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inflight", 32'(inflight), 0);
    chk("post_rst_rsp_r", rsp_r, 0);
    chk("post_rst_grant", 32'(req_ready), 32'b0100);
    sb.push_back('{2, vr[0], cyc + LAT + 2});
    @(posedge clk); #1;
    req_valid = '0;
    idle(LAT + 4);

    // spurious dst_valid
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    idle(1);
    @(negedge clk);
    chk("err_unexp_set", 32'(err_unexp), 1);
    chk("err_miss_clear", 32'(err_miss), 0);
    @(posedge clk); #1;

    // suppressed dst_valid
    issue(1, 1, 0);
    kill_src = 1'b1;
    @(posedge clk); #1;
    kill_src = 1'b0;
    idle(LAT + 2);
    @(negedge clk);
    chk("err_miss_set", 32'(err_miss), 1);
    chk("err_unexp_hold", 32'(err_unexp), 1);
    @(posedge clk); #1;

    // normal op after errors; flags stay sticky
    issue(0, 5, 1);
    idle(LAT + 3);
    @(negedge clk);
    chk("errs_sticky", 32'({err_unexp, err_miss}), 32'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("errs_cleared", 32'({err_unexp, err_miss}), 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
